// File: rtl/toggle_sequencer.sv
// toggle_sequencer
//   Command-driven controller for a WIDTH-bit register built from T stages.
//   Each accepted command produces a toggle vector over one or more EXEC cycles.
//   The register only ever updates as q <= q ^ t_vec.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a command, cmd_ready high
//   EXEC  | applying t_vec, one step per cycle, remaining-step counter runs down
//   DONE  | one-cycle completion pulse, wrapped valid
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  high in IDLE; accept = cmd_valid & cmd_ready at an edge
//   cmd_op     00 TOGGLE, 01 COUNT_UP, 10 COUNT_DOWN, 11 CLEAR
//   cmd_arg    toggle mask (TOGGLE) or step count (COUNT_*); ignored for CLEAR
//   q / qbar   T-stage register and its inverse
//   t_vec      toggle vector applied at the next edge (0 outside EXEC)
//   busy       high in EXEC and DONE
//   done       high exactly in DONE
//   wrapped    high with done if any count step wrapped during the command
module toggle_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             done,
  output logic             wrapped
);

  localparam logic [1:0] OP_TOGGLE = 2'b00;
  localparam logic [1:0] OP_UP     = 2'b01;
  localparam logic [1:0] OP_DOWN   = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] cnt_r;
  logic             wrap_r;

  logic             accept;
  logic             cmd_is_count;
  logic             step_wraps;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] t_vec_c;
  logic [WIDTH-1:0] low_mask;

  assign accept       = cmd_valid && (state == IDLE);
  assign cmd_is_count = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);

  // Carry/borrow chains written as independent prefix reductions so no
  // bit of the chain depends on another bit of the same vector.
  always_comb begin
    up_t     = '0;
    dn_t     = '0;
    low_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      low_mask = (WIDTH'(1) << i) - WIDTH'(1);
      up_t[i]  = &(q_r | ~low_mask);
      dn_t[i]  = &(~q_r | ~low_mask);
    end
  end

  always_comb begin
    t_vec_c    = '0;
    step_wraps = 1'b0;
    if (state == EXEC) begin
      case (op_r)
        OP_TOGGLE: t_vec_c = mask_r;
        OP_UP: begin
          t_vec_c    = up_t;
          step_wraps = &q_r;
        end
        OP_DOWN: begin
          t_vec_c    = dn_t;
          step_wraps = (q_r == '0);
        end
        default:   t_vec_c = q_r;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_is_count && (cmd_arg == '0)) state_nxt = DONE;
          else                                 state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt_r == WIDTH'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      q_r    <= '0;
      op_r   <= OP_TOGGLE;
      mask_r <= '0;
      cnt_r  <= '0;
      wrap_r <= 1'b0;
    end else begin
      state <= state_nxt;
      q_r   <= q_r ^ t_vec_c;
      if (accept) begin
        op_r   <= cmd_op;
        mask_r <= cmd_arg;
        // TOGGLE and CLEAR are single-step commands.
        cnt_r  <= cmd_is_count ? cmd_arg : WIDTH'(1);
        wrap_r <= 1'b0;
      end else if (state == EXEC) begin
        cnt_r <= cnt_r - WIDTH'(1);
        if (step_wraps) wrap_r <= 1'b1;
      end
    end
  end

  assign q         = q_r;
  assign qbar      = ~q_r;
  assign t_vec     = t_vec_c;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign wrapped   = (state == DONE) && wrap_r;

endmodule

// File: tb/tb_toggle_sequencer.sv
// Directed bench for toggle_sequencer (WIDTH = 8).
module tb_toggle_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic [7:0] q;
  logic [7:0] qbar;
  logic [7:0] t_vec;
  logic       busy;
  logic       done;
  logic       wrapped;

  int checks = 0;
  int errors = 0;

  toggle_sequencer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .q         (q),
    .qbar      (qbar),
    .t_vec     (t_vec),
    .busy      (busy),
    .done      (done),
    .wrapped   (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command, count EXEC cycles until done, capture wrapped, return to IDLE.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] arg,
                         output int execs, output logic wr);
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    execs = 0;
    wr    = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      execs++;
      step();
    end
    chk("run_done_seen", {31'd0, done}, 32'd1);
    wr = wrapped;
    step();
  endtask

  int         execs;
  logic       wr;
  int         busy_cnt;
  int         done_cnt;
  logic [7:0] up_exp [4];

  initial begin
    up_exp[0] = 8'hFE; up_exp[1] = 8'hFF; up_exp[2] = 8'h00; up_exp[3] = 8'h01;

    // Reset with a command pending: reset must win.
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00; cmd_arg = 8'hFF;
    step();
    step();
    chk("rst_q", {24'd0, q}, 32'h00);
    chk("rst_qbar", {24'd0, qbar}, 32'hFF);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0; cmd_valid = 1'b0;
    step();
    chk("rst_no_accept_busy", {31'd0, busy}, 32'd0);
    chk("rst_no_accept_q", {24'd0, q}, 32'h00);

    // TOGGLE 0xA5
    cmd_op = 2'b00; cmd_arg = 8'hA5; cmd_valid = 1'b1;
    chk("tog_ready_pre", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("tog_busy", {31'd0, busy}, 32'd1);
    chk("tog_ready_exec", {31'd0, cmd_ready}, 32'd0);
    chk("tog_tvec", {24'd0, t_vec}, 32'hA5);
    chk("tog_done_exec", {31'd0, done}, 32'd0);
    step();
    chk("tog_q", {24'd0, q}, 32'hA5);
    chk("tog_qbar", {24'd0, qbar}, 32'h5A);
    chk("tog_done", {31'd0, done}, 32'd1);
    chk("tog_ready_done", {31'd0, cmd_ready}, 32'd0);
    step();
    chk("tog_done_clear", {31'd0, done}, 32'd0);
    chk("tog_ready_back", {31'd0, cmd_ready}, 32'd1);
    chk("tog_tvec_idle", {24'd0, t_vec}, 32'h00);

    // Move to 0xFD, then COUNT_UP 4 with wrap.
    run_cmd(2'b00, 8'h58, execs, wr);
    chk("set_fd_q", {24'd0, q}, 32'hFD);
    chk("set_fd_execs", execs, 1);
    cmd_op = 2'b01; cmd_arg = 8'd4; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("up_tvec_first", {24'd0, t_vec}, 32'h03);
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("up_q_%0d", i), {24'd0, q}, {24'd0, up_exp[i]});
      busy_cnt += busy ? 1 : 0;
    end
    chk("up_done", {31'd0, done}, 32'd1);
    chk("up_wrapped", {31'd0, wrapped}, 32'd1);
    step();
    busy_cnt += busy ? 1 : 0;
    chk("up_busy_cycles", busy_cnt, 5);
    chk("up_wrapped_after", {31'd0, wrapped}, 32'd0);

    // 0x01 -> 0x02, COUNT_DOWN 2 (no wrap), then COUNT_DOWN 1 (wrap).
    run_cmd(2'b00, 8'h03, execs, wr);
    chk("set_02_q", {24'd0, q}, 32'h02);
    cmd_op = 2'b10; cmd_arg = 8'd2; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("dn_tvec_first", {24'd0, t_vec}, 32'h03);
    step();
    chk("dn_q_0", {24'd0, q}, 32'h01);
    chk("dn_done_mid", {31'd0, done}, 32'd0);
    step();
    chk("dn_q_1", {24'd0, q}, 32'h00);
    chk("dn_done", {31'd0, done}, 32'd1);
    chk("dn_wrapped", {31'd0, wrapped}, 32'd0);
    step();
    run_cmd(2'b10, 8'd1, execs, wr);
    chk("dn1_q", {24'd0, q}, 32'hFF);
    chk("dn1_execs", execs, 1);
    chk("dn1_wrapped", {31'd0, wr}, 32'd1);

    // COUNT_UP 0: straight to DONE, nothing changes.
    run_cmd(2'b01, 8'd0, execs, wr);
    chk("up0_execs", execs, 0);
    chk("up0_q", {24'd0, q}, 32'hFF);
    chk("up0_wrapped", {31'd0, wr}, 32'd0);

    // 0xFF -> 0x3C, then CLEAR.
    run_cmd(2'b00, 8'hC3, execs, wr);
    chk("set_3c_q", {24'd0, q}, 32'h3C);
    cmd_op = 2'b11; cmd_arg = 8'h81; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("clr_tvec", {24'd0, t_vec}, 32'h3C);
    step();
    chk("clr_q", {24'd0, q}, 32'h00);
    chk("clr_done", {31'd0, done}, 32'd1);
    step();

    // cmd_valid held through EXEC with changing op/arg: no second accept.
    cmd_op = 2'b01; cmd_arg = 8'd3; cmd_valid = 1'b1;
    step();
    cmd_op = 2'b00; cmd_arg = 8'hFF;
    step();
    step();
    step();
    chk("hold_q", {24'd0, q}, 32'h03);
    chk("hold_done", {31'd0, done}, 32'd1);
    step();
    chk("hold_ready", {31'd0, cmd_ready}, 32'd1);
    chk("hold_q_idle", {24'd0, q}, 32'h03);
    cmd_valid = 1'b0;
    step();
    chk("hold_no_accept", {31'd0, busy}, 32'd0);

    // Reset during the 3rd EXEC cycle of COUNT_UP 10.
    cmd_op = 2'b01; cmd_arg = 8'd10; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("abort_q_pre", {24'd0, q}, 32'h05);
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_q", {24'd0, q}, 32'h00);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    done_cnt = done ? 1 : 0;
    for (int i = 0; i < 15; i++) begin
      step();
      done_cnt += done ? 1 : 0;
    end
    chk("abort_no_done", done_cnt, 0);
    chk("abort_q_hold", {24'd0, q}, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
